core_decode_queue: RTL and testbench
====================================

CORE_DECODE_QUEUE -- requirements
Module: core_decode_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the queue entry count; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port flush, input, 1 bit: discard all queued and presented instructions.
REQ-005 The block SHALL have port in_valid, input, 1 bit: fetch offers an instruction.
REQ-006 The block SHALL have port in_ready, output, 1 bit: queue accepts this cycle.
REQ-007 The block SHALL have port in_insn, input, word: raw instruction.
REQ-008 The block SHALL have port in_pc, input, word: instruction address.
REQ-009 The block SHALL have port in_abort, input, 1 bit: prefetch abort on this fetch.
REQ-010 The block SHALL have port out_valid, output, 1 bit: decoded head entry is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream consumes the head.
REQ-012 The block SHALL have port out_dec, output, insn_decode: decoded head.
REQ-013 The block SHALL have port out_pc, output, word: head address.
REQ-014 The block SHALL have port out_abort, output, 1 bit: head carries a prefetch abort.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: occupancy.

Function
REQ-016 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-017 in_ready SHALL equal (count < DEPTH) and SHALL be driven from registered state only, with no combinational path from out_ready.
REQ-018 When full, a pop and a push offered in the same cycle SHALL pop only; the push is refused because in_ready=0.
REQ-019 A simultaneous push and pop when not full SHALL leave count unchanged and keep FIFO order.
REQ-020 Latency: an instruction pushed in cycle N into an empty queue SHALL be presented with out_valid=1 in cycle N+1.
REQ-021 out_valid SHALL equal (count != 0), and out_pc and out_abort SHALL come from the head entry registers.
REQ-022 out_dec SHALL be the combinational decode of the head entry's insn.
REQ-023 If the head entry has abort=1, out_dec.ctrl SHALL have execute, writeback, branch, ldst, mul, psr, coproc, swi, bkpt and undefined all forced to 0, and out_abort=1.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full and empty SHALL be derived from the MSB and index comparison.
REQ-025 out_dec, out_pc and out_abort SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 On flush, the next cycle SHALL have count=0, out_valid=0 and in_ready=1; any push or pop in the flush cycle is dropped.
REQ-027 Entries whose decode is undefined SHALL be queued and presented unchanged; trapping is downstream's job.

Reset
REQ-028 While rst_n=0 at a clock edge, pointers and count SHALL clear to 0.
REQ-029 During that reset, out_valid SHALL be 0 and in_ready SHALL be 1 from the following cycle.
REQ-030 Entry payload storage SHALL NOT be reset, and out_dec SHALL be don't-care while out_valid=0.
REQ-031 Reset asserted mid-stream SHALL discard all entries, with priority over flush, push and pop.

Structure
REQ-032 The shared package SHALL hold typedef decode_queue_entry {word insn; word pc; logic abort;} and the default depth constant.
REQ-033 The block SHALL instantiate exactly one core_decode on the head entry; entry storage SHALL be a flat register array indexed by pointer.

Verification
REQ-034 Single push: push 0xE3A01005 (MOV r1,#5) at pc 0x100 -> out_valid=1 the next cycle, out_pc=0x100, out_dec.ctrl.execute=1, out_abort=0.
REQ-035 Fill and backpressure: DEPTH=4, out_ready=0, push 5 words -> in_ready=0 after the 4th, count=4, 5th not accepted; then out_ready=1 -> outputs in order pc 0x0,0x4,0x8,0xC.
REQ-036 Abort: push any insn with in_abort=1 at pc 0x200 -> out_abort=1, out_dec.ctrl.execute=0 and writeback=0.
REQ-037 Flush: count=3 with flush=1, in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, nothing popped or pushed.
REQ-038 Streaming: in_valid=1 and out_ready=1 continuously over 20 instructions -> count stays at 1 after the first, zero drops or duplicates, and pointers wrap without error.
REQ-039 Reset: rst_n=0 for one edge with count=2 -> count=0, out_valid=0, in_ready=1 on the following cycle.

Source files
------------

// File: rtl/core_decode_queue_pkg.sv
// Shared types for the decode queue: machine word, queue entry and the
// decoded-instruction record produced by core_decode.
package core_decode_queue_pkg;

   typedef logic [31:0] word;

   localparam int DEFAULT_DEPTH = 4;

   // One queued fetch: raw instruction, its address and prefetch-abort flag.
   typedef struct packed {
      word  insn;
      word  pc;
      logic abort;
   } decode_queue_entry;

   // Control flags; an aborted fetch clears every one of them.
   typedef struct packed {
      logic execute;
      logic writeback;
      logic branch;
      logic ldst;
      logic mul;
      logic psr;
      logic coproc;
      logic swi;
      logic bkpt;
      logic undefined;
   } insn_ctrl;

   typedef struct packed {
      logic [3:0] cond;
      logic [3:0] opcode;
      logic [3:0] rn;
      logic [3:0] rd;
      logic [3:0] rm;
      insn_ctrl   ctrl;
   } insn_decode;

endpackage

// File: rtl/core_decode_queue_decode.sv
// Combinational ARM-style instruction classifier applied to the queue head.
module core_decode
   import core_decode_queue_pkg::*;
(
   input  word        insn_i,
   output insn_decode dec_o
);

   // Classify the instruction by its major opcode group and fill the control flags.
   always_comb begin
      // NOTE: every output gets a default before any branch so no path leaves
      // a bit unassigned; that is what keeps this block from inferring latches.
      dec_o              = '0;
      dec_o.cond         = insn_i[31:28];
      dec_o.opcode       = insn_i[24:21];
      dec_o.rn           = insn_i[19:16];
      dec_o.rd           = insn_i[15:12];
      dec_o.rm           = insn_i[3:0];
      dec_o.ctrl.execute = (insn_i[31:28] != 4'hF);

      unique case (insn_i[27:25])
         3'b000: begin
            if (insn_i[27:20] == 8'h12 && insn_i[7:4] == 4'h7) begin
               dec_o.ctrl.bkpt = 1'b1;
            end else if (insn_i[27:4] == 24'h12FFF1) begin
               dec_o.ctrl.branch = 1'b1;
            end else if (insn_i[27:24] == 4'h0 && insn_i[7:4] == 4'h9) begin
               dec_o.ctrl.mul       = 1'b1;
               dec_o.ctrl.writeback = 1'b1;
            end else if (insn_i[7] && insn_i[4]) begin
               // Halfword / signed transfers share the register-shift space.
               dec_o.ctrl.ldst      = 1'b1;
               dec_o.ctrl.writeback = insn_i[20];
            end else if (insn_i[24:23] == 2'b10 && !insn_i[20]) begin
               dec_o.ctrl.psr       = 1'b1;
               dec_o.ctrl.writeback = !insn_i[21];
            end else begin
               // Compare/test opcodes only set flags.
               dec_o.ctrl.writeback = (insn_i[24:23] != 2'b10);
            end
         end
         3'b001: begin
            if (insn_i[24:23] == 2'b10 && !insn_i[20]) begin
               dec_o.ctrl.psr = 1'b1;
            end else begin
               dec_o.ctrl.writeback = (insn_i[24:23] != 2'b10);
            end
         end
         3'b010: begin
            dec_o.ctrl.ldst      = 1'b1;
            dec_o.ctrl.writeback = insn_i[20];
         end
         3'b011: begin
            // Register-offset transfer with bit 4 set is the undefined space.
            if (insn_i[4]) begin
               dec_o.ctrl.undefined = 1'b1;
            end else begin
               dec_o.ctrl.ldst      = 1'b1;
               dec_o.ctrl.writeback = insn_i[20];
            end
         end
         3'b100: begin
            dec_o.ctrl.ldst      = 1'b1;
            dec_o.ctrl.writeback = insn_i[20];
         end
         3'b101: begin
            dec_o.ctrl.branch    = 1'b1;
            dec_o.ctrl.writeback = insn_i[24];
         end
         3'b110: begin
            dec_o.ctrl.coproc = 1'b1;
         end
         default: begin
            if (insn_i[24]) dec_o.ctrl.swi    = 1'b1;
            else            dec_o.ctrl.coproc = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/core_decode_queue.sv
// Decode queue: a small FIFO between fetch and execute that presents the
// decoded head entry. in_ready depends only on registered pointers.
module core_decode_queue
   import core_decode_queue_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  word                      in_insn,
   input  word                      in_pc,
   input  logic                     in_abort,
   output logic                     out_valid,
   input  logic                     out_ready,
   output insn_decode               out_dec,
   output word                      out_pc,
   output logic                     out_abort,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH) + 1;
   localparam int IW = PW - 1;
   localparam logic [PW-1:0] PTR_ONE = 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   decode_queue_entry entry_q [DEPTH];
   decode_queue_entry head;
   insn_decode        head_dec;
   logic              full, empty, push, pop;

   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign count     = wr_ptr_q - rd_ptr_q;

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   // Next pointer values: flush empties the queue and drops that cycle's push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // Pointer registers; reset wins over flush, push and pop.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Payload storage written at the tail on push.
   always_ff @(posedge clk) begin
      // NOTE: payload is deliberately not reset; the pointers alone decide
      // which entries are live, so stale data is never presented as valid.
      if (push) begin
         entry_q[wr_ptr_q[IW-1:0]] <= '{insn: in_insn, pc: in_pc, abort: in_abort};
      end
   end

   assign head      = entry_q[rd_ptr_q[IW-1:0]];
   assign out_pc    = head.pc;
   assign out_abort = head.abort;

   core_decode u_decode (
      .insn_i (head.insn),
      .dec_o  (head_dec)
   );

   // An aborted fetch must not do anything downstream: clear all control flags.
   always_comb begin
      out_dec = head_dec;
      if (head.abort) out_dec.ctrl = '0;
   end

endmodule

// File: tb/tb_core_decode_queue.sv
// Bench for core_decode_queue: directed stimulus pushes expected head
// contents into a scoreboard; a monitor pops and compares on every pop.
module tb_core_decode_queue;
   import core_decode_queue_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, flush, in_valid, in_ready, in_abort;
   logic       out_valid, out_ready, out_abort;
   word        in_insn, in_pc, out_pc;
   insn_decode out_dec;
   logic [2:0] count;

   typedef struct {
      word  pc;
      logic abort, exe, wb, br, undef;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   core_decode_queue #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_insn   (in_insn),
      .in_pc     (in_pc),
      .in_abort  (in_abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dec   (out_dec),
      .out_pc    (out_pc),
      .out_abort (out_abort),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
      else             n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one fetch offer; expected results are hand-computed by the caller.
   task automatic offer(input word insn, input word pc, input logic abort);
      in_valid = 1'b1;
      in_insn  = insn;
      in_pc    = pc;
      in_abort = abort;
   endtask

   task automatic expect_pop(input word pc, input logic abort, input logic exe,
                             input logic wb, input logic br, input logic undef);
      exp_t e;
      e.pc = pc; e.abort = abort; e.exe = exe; e.wb = wb; e.br = br; e.undef = undef;
      sb.push_back(e);
   endtask

   // Monitor: a pop happens at the next rising edge whenever this condition holds.
   always @(negedge clk) begin
      if (rst_n && !flush && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pop: got pc %h want no entry", out_pc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pop_pc",        out_pc,                     e.pc);
            check("pop_abort",     32'(out_abort),             32'(e.abort));
            check("pop_execute",   32'(out_dec.ctrl.execute),  32'(e.exe));
            check("pop_writeback", 32'(out_dec.ctrl.writeback), 32'(e.wb));
            check("pop_branch",    32'(out_dec.ctrl.branch),   32'(e.br));
            check("pop_undefined", 32'(out_dec.ctrl.undefined), 32'(e.undef));
         end
      end
   end

   // Streaming patterns: insn, writeback, branch, undefined (all execute=1).
   word  pat_insn  [5] = '{32'hE3A01005, 32'hE3500000, 32'hEA000000, 32'hEB000000, 32'hE7F000F0};
   logic pat_wb    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic pat_br    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic pat_undef [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_insn = '0;
      in_pc = '0; in_abort = 1'b0; out_ready = 1'b0;
      #1;
      tick(); tick();
      rst_n = 1'b1;
      check("reset_count",     32'(count),     0);
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_in_ready",  32'(in_ready),  1);

      // Single push: visible the very next cycle.
      offer(32'hE3A01005, 32'h100, 1'b0);
      expect_pop(32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      check("single_out_valid", 32'(out_valid), 1);
      check("single_count",     32'(count),     1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("single_drained", 32'(count), 0);

      // Aborted fetch: control flags cleared, abort flagged.
      offer(32'hE3A01005, 32'h200, 1'b1);
      expect_pop(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0; in_abort = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Streaming 20 instructions through a 4-deep queue.
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         offer(pat_insn[i % 5], 32'h1000 + 32'(4 * i), 1'b0);
         expect_pop(32'h1000 + 32'(4 * i), 1'b0, 1'b1, pat_wb[i % 5], pat_br[i % 5], pat_undef[i % 5]);
         tick();
         check("stream_count", 32'(count), 1);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      check("stream_drained", 32'(count), 0);

      // Fill with backpressure: fifth offer refused.
      for (int i = 0; i < 5; i++) begin
         offer(32'hE3A00000 + 32'(i), 32'(4 * i), 1'b0);
         if (i < 4) begin
            check("fill_in_ready", 32'(in_ready), 1);
            expect_pop(32'(4 * i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         end else begin
            check("full_in_ready", 32'(in_ready), 0);
         end
         tick();
      end
      check("full_count",    32'(count),     4);
      check("full_in_ready", 32'(in_ready),  0);
      check("full_head_pc",  out_pc,         32'h0);
      tick();
      check("stall_head_pc",  out_pc,        32'h0);
      check("stall_head_dec", 32'(out_dec.ctrl.writeback), 1);
      check("stall_count",    32'(count),    4);
      // Full with pop and push offered together: pop only.
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("full_pop_only_count", 32'(count), 3);
      tick(); tick(); tick();
      out_ready = 1'b0;
      check("fill_drained", 32'(count), 0);

      // Flush with push and pop offered in the same cycle.
      for (int i = 0; i < 3; i++) begin
         offer(32'hE3A00000, 32'h400 + 32'(4 * i), 1'b0);
         tick();
      end
      check("preflush_count", 32'(count), 3);
      flush = 1'b1; out_ready = 1'b1;
      offer(32'hE3A00000, 32'h40C, 1'b0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_count",     32'(count),     0);
      check("flush_out_valid", 32'(out_valid), 0);
      check("flush_in_ready",  32'(in_ready),  1);
      out_ready = 1'b0;

      // Reset mid-stream with two entries held.
      for (int i = 0; i < 2; i++) begin
         offer(32'hE3A00000, 32'h600 + 32'(4 * i), 1'b0);
         tick();
      end
      check("prereset_count", 32'(count), 2);
      rst_n = 1'b0; out_ready = 1'b1;
      offer(32'hE3A00000, 32'h608, 1'b0);
      tick();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      check("midreset_count",     32'(count),     0);
      check("midreset_out_valid", 32'(out_valid), 0);
      check("midreset_in_ready",  32'(in_ready),  1);

      // Queue still works after reset.
      offer(32'hEA000000, 32'h500, 1'b0);
      expect_pop(32'h500, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();

      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
